// File: rtl/mem_access_unit_if.sv
// Core-side request/response handshake and word-aligned memory bus of the
// load/store unit. The unit itself connects through the slave modport.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_enable;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_enable, mem_write, mem_address, mem_data_in
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_enable, mem_write, mem_address, mem_data_in
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit between the core and a byte-addressed, word-wide memory.
// Sub-word stores are done as read-modify-write; sub-word loads are extracted
// and optionally sign-extended; unaligned word loads are rotated.
module mem_access_unit #(
    parameter int unsigned MEM_SIZE = 64000
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_access_unit_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_write;
    logic        r_fault;

    logic        w_accept;
    logic        w_fault;
    logic [32:0] w_end;
    logic [31:0] w_byte_sh;
    logic [31:0] w_half_sh;
    logic [63:0] w_rot;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);

    // Fault decode on the incoming request; the end address is 33 bits wide
    // so that addresses near 0xFFFFFFFF cannot wrap below MEM_SIZE.
    always_comb begin
        w_end   = {1'b0, bus.req_addr} + 33'd3;
        w_fault = 1'b0;
        if (bus.req_size == 2'b11)
            w_fault = 1'b1;
        else if (bus.req_size == 2'b01 && bus.req_addr[0])
            w_fault = 1'b1;
        else if (w_end >= 33'(MEM_SIZE))
            w_fault = 1'b1;
    end

    // Load result formatting and sub-word store merge from the returned word.
    always_comb begin
        w_byte_sh = bus.mem_data_out >> {r_addr[1:0], 3'b000};
        w_half_sh = bus.mem_data_out >> {r_addr[1], 4'b0000};
        w_rot     = {bus.mem_data_out, bus.mem_data_out} >> {r_addr[1:0], 3'b000};
        w_merged  = bus.mem_data_out;
        case (r_size)
            2'b00: begin
                w_load = {{24{r_signed & w_byte_sh[7]}}, w_byte_sh[7:0]};
                w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            end
            2'b01: begin
                w_load = {{16{r_signed & w_half_sh[15]}}, w_half_sh[15:0]};
                w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            end
            default: begin
                w_load = w_rot[31:0];
            end
        endcase
    end

    // Access sequencer: latches the request, runs read / write phases, and
    // produces the response word and fault flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_write  <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        r_size   <= bus.req_size;
                        r_signed <= bus.req_signed;
                        r_write  <= bus.req_write;
                        r_fault  <= w_fault;
                        if (w_fault) begin
                            r_rdata <= '0;
                            r_state <= S_RESP;
                        end else if (bus.req_write && bus.req_size == 2'b10) begin
                            r_state <= S_WR;
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (r_write) begin
                        r_wdata <= w_merged;
                        r_state <= S_WR;
                    end else begin
                        r_rdata <= w_load;
                        r_state <= S_RESP;
                    end
                end
                S_WR: begin
                    r_rdata <= '0;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_fault <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.resp_valid  = (r_state == S_RESP);
    assign bus.resp_fault  = r_fault;
    assign bus.resp_rdata  = r_rdata;
    assign bus.mem_enable  = (r_state == S_RD) || (r_state == S_WR);
    assign bus.mem_write   = (r_state == S_WR);
    assign bus.mem_address = {r_addr[31:2], 2'b00};
    assign bus.mem_data_in = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word-wide memory and
// a scoreboard of expected responses.
module tb_mem_access_unit;

    localparam int unsigned MEM_SIZE = 64000;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mem_access_unit_if bus_if();

    mem_access_unit #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: registered read data, byte array storage.
    logic [7:0] mem [0:MEM_SIZE-1];
    int rd_cnt = 0;
    int wr_cnt = 0;

    always @(posedge clk) begin
        if (bus_if.mem_enable) begin
            if (bus_if.mem_write) begin
                wr_cnt = wr_cnt + 1;
                if (bus_if.mem_address < MEM_SIZE - 3) begin
                    mem[bus_if.mem_address]     <= bus_if.mem_data_in[7:0];
                    mem[bus_if.mem_address + 1] <= bus_if.mem_data_in[15:8];
                    mem[bus_if.mem_address + 2] <= bus_if.mem_data_in[23:16];
                    mem[bus_if.mem_address + 3] <= bus_if.mem_data_in[31:24];
                end
            end else begin
                rd_cnt = rd_cnt + 1;
                if (bus_if.mem_address < MEM_SIZE - 3)
                    bus_if.mem_data_out <= {mem[bus_if.mem_address + 3], mem[bus_if.mem_address + 2],
                                            mem[bus_if.mem_address + 1], mem[bus_if.mem_address]};
                else
                    bus_if.mem_data_out <= 32'hDEAD_DEAD;
            end
        end
    end

    function automatic logic [31:0] mem_word(input int unsigned a);
        return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
    endfunction

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          nrd;
        int          nwr;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic issue(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] e_rdata, input logic e_fault, input int e_lat,
                         input int e_rd, input int e_wr);
        exp_t e;
        int   rd0, wr0, lat;
        bit   got;
        sb.push_back('{tag, e_rdata, e_fault, e_lat, e_rd, e_wr});
        @(negedge clk);
        chk({tag, ".ready"}, {31'd0, bus_if.req_ready}, 32'd1);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        bus_if.req_valid  = 1'b1;
        bus_if.req_write  = wr;
        bus_if.req_size   = sz;
        bus_if.req_signed = sg;
        bus_if.req_addr   = addr;
        bus_if.req_wdata  = wdata;
        @(posedge clk);
        #1;
        // Garbage on the request lines while busy must be ignored.
        bus_if.req_valid  = 1'b1;
        bus_if.req_write  = 1'b1;
        bus_if.req_size   = 2'b10;
        bus_if.req_signed = 1'b1;
        bus_if.req_addr   = 32'h0000_0200;
        bus_if.req_wdata  = $urandom;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus_if.resp_valid) got = 1'b1;
        end
        bus_if.req_valid = 1'b0;
        e = sb.pop_front();
        chk({e.tag, ".resp_seen"}, {31'd0, got}, 32'd1);
        chk({e.tag, ".latency"}, 32'(lat), 32'(e.lat));
        chk({e.tag, ".rdata"}, bus_if.resp_rdata, e.rdata);
        chk({e.tag, ".fault"}, {31'd0, bus_if.resp_fault}, {31'd0, e.fault});
        chk({e.tag, ".reads"}, 32'(rd_cnt - rd0), 32'(e.nrd));
        chk({e.tag, ".writes"}, 32'(wr_cnt - wr0), 32'(e.nwr));
        @(negedge clk);
        chk({e.tag, ".pulse"}, {31'd0, bus_if.resp_valid}, 32'd0);
    endtask

    initial begin
        int wr0;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus_if.req_valid  = 1'b0;
        bus_if.req_write  = 1'b0;
        bus_if.req_size   = 2'b00;
        bus_if.req_signed = 1'b0;
        bus_if.req_addr   = '0;
        bus_if.req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", {31'd0, bus_if.req_ready}, 32'd1);
        chk("rst.resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
        chk("rst.mem_enable", {31'd0, bus_if.mem_enable}, 32'd0);
        chk("rst.rdata", bus_if.resp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // tag, wr, size, signed, addr, wdata, rdata, fault, latency, reads, writes
        issue("sw_100",   1'b1, 2'b10, 1'b0, 32'h100, 32'h1122_3344, 32'h0,         1'b0, 2, 0, 1);
        issue("lw_100a",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0,         32'h1122_3344, 1'b0, 3, 1, 0);
        issue("sb_102",   1'b1, 2'b00, 1'b0, 32'h102, 32'h1234_56AB, 32'h0,         1'b0, 4, 1, 1);
        issue("lw_100b",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0,         32'h11AB_3344, 1'b0, 3, 1, 0);
        issue("lbs_102",  1'b0, 2'b00, 1'b1, 32'h102, 32'h0,         32'hFFFF_FFAB, 1'b0, 3, 1, 0);
        issue("lbu_102",  1'b0, 2'b00, 1'b0, 32'h102, 32'h0,         32'h0000_00AB, 1'b0, 3, 1, 0);
        issue("lhs_102",  1'b0, 2'b01, 1'b1, 32'h102, 32'h0,         32'h0000_11AB, 1'b0, 3, 1, 0);
        issue("lw_101",   1'b0, 2'b10, 1'b0, 32'h101, 32'h0,         32'h4411_AB33, 1'b0, 3, 1, 0);
        issue("lw_103",   1'b0, 2'b10, 1'b0, 32'h103, 32'h0,         32'hAB33_4411, 1'b0, 3, 1, 0);
        issue("sh_100",   1'b1, 2'b01, 1'b0, 32'h100, 32'hFFFF_8001, 32'h0,         1'b0, 4, 1, 1);
        issue("lhs_100",  1'b0, 2'b01, 1'b1, 32'h100, 32'h0,         32'hFFFF_8001, 1'b0, 3, 1, 0);
        issue("lhu_100",  1'b0, 2'b01, 1'b0, 32'h100, 32'h0,         32'h0000_8001, 1'b0, 3, 1, 0);
        chk("mem_100_merged", mem_word(32'h100), 32'h11AB_8001);

        issue("flt_lh101", 1'b0, 2'b01, 1'b1, 32'h101,       32'h0,  32'h0, 1'b1, 1, 0, 0);
        issue("flt_lw_end", 1'b0, 2'b10, 1'b0, 32'd63997,    32'h0,  32'h0, 1'b1, 1, 0, 0);
        issue("flt_size3", 1'b0, 2'b11, 1'b0, 32'h100,       32'h0,  32'h0, 1'b1, 1, 0, 0);
        issue("flt_sw_top", 1'b1, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 32'h0, 1'b1, 1, 0, 0);
        chk("mem_100_after_faults", mem_word(32'h100), 32'h11AB_8001);

        issue("sw_last",  1'b1, 2'b10, 1'b0, 32'd63996, 32'hCAFE_F00D, 32'h0,         1'b0, 2, 0, 1);
        issue("lw_last",  1'b0, 2'b10, 1'b0, 32'd63996, 32'h0,         32'hCAFE_F00D, 1'b0, 3, 1, 0);
        issue("sw_104",   1'b1, 2'b10, 1'b0, 32'h104,   32'hDEAD_BEEF, 32'h0,         1'b0, 2, 0, 1);

        // Reset while the byte store to 0x104 is waiting on its read data.
        @(negedge clk);
        wr0 = wr_cnt;
        bus_if.req_valid  = 1'b1;
        bus_if.req_write  = 1'b1;
        bus_if.req_size   = 2'b00;
        bus_if.req_signed = 1'b0;
        bus_if.req_addr   = 32'h104;
        bus_if.req_wdata  = 32'h0000_0055;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        @(negedge clk);
        chk("rmw.rd_phase", {30'd0, bus_if.mem_enable, bus_if.mem_write}, 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rmw_rst.ready", {31'd0, bus_if.req_ready}, 32'd1);
        chk("rmw_rst.ctrl", {28'd0, bus_if.resp_valid, bus_if.resp_fault,
                             bus_if.mem_enable, bus_if.mem_write}, 32'd0);
        chk("rmw_rst.rdata", bus_if.resp_rdata, 32'd0);
        chk("rmw_rst.addr", bus_if.mem_address, 32'd0);
        chk("rmw_rst.wdata", bus_if.mem_data_in, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rmw_rst.no_write", 32'(wr_cnt - wr0), 32'd0);
        chk("rmw_rst.mem_104", mem_word(32'h104), 32'hDEAD_BEEF);
        issue("lw_104",   1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1, 0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
